iddr_align_ctrl: RTL and testbench
==================================

IDDR_ALIGN_CTRL -- requirements
Module: iddr_align_ctrl

Interface
REQ-001 The block SHALL have parameter MATCH_N, default 4: consecutive matching training words required to declare lock (range 1..15).
REQ-002 The block SHALL have parameter RST_CYC, default 4: cycles DDR_R is held high during primitive reset (range 1..15).
REQ-003 The block SHALL have port CLK, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port START, input, 1 bit: single-cycle request to begin (or restart) training.
REQ-006 The block SHALL have port PATTERN, input, 8 bits: training word; must be stable while training.
REQ-007 The block SHALL have port DDR_Q, input, 2 bits: I_DDR output; bit 0 is the rising-edge (earlier) sample, bit 1 the falling-edge (later) sample.
REQ-008 The block SHALL have port DDR_R, output, 1 bit: active-high reset to I_DDR.
REQ-009 The block SHALL have port DDR_E, output, 1 bit: enable to I_DDR.
REQ-010 The block SHALL have port WORD, output, 8 bits: aligned deserialized word, MSB earliest bit.
REQ-011 The block SHALL have port WORD_VALID, output, 1 bit: one-cycle strobe, WORD valid, LOCKED state only.
REQ-012 The block SHALL have port LOCKED, output, 1 bit: alignment achieved.
REQ-013 The block SHALL have port FAIL, output, 1 bit: all 8 slip offsets tried without lock.
REQ-014 The block SHALL have port SLIP, output, 3 bits: current bit-slip offset.

Function
REQ-015 History: every cycle with DDR_E high, a 16-bit register SHALL shift as hist <= {hist[13:0], DDR_Q[0], DDR_Q[1]}.
REQ-016 Window: the candidate word SHALL be hist[SLIP+7:SLIP]; SLIP=0 selects the 8 newest bits.
REQ-017 Phase: a 2-bit counter SHALL run 0..3 and wrap while DDR_E is high; a word strobe occurs when phase==3 (one word per 4 cycles).
REQ-018 States SHALL be IDLE, PRST, TRAIN, SLIPW, LOCK and FAILED.
REQ-019 IDLE: DDR_R=0, DDR_E=0; on START go to PRST.
REQ-020 PRST: DDR_R=1, DDR_E=0 for exactly RST_CYC cycles; then clear phase, hist and match count, and go to TRAIN.
REQ-021 TRAIN: at each strobe, window==PATTERN increments the match count, otherwise the count clears to 0 and the state goes to SLIPW.
REQ-022 TRAIN: when the match count reaches MATCH_N, go to LOCK; WORD/WORD_VALID begin at the next strobe.
REQ-023 SLIPW: on entry, SLIP increments; discard the next 2 strobes, then return to TRAIN.
REQ-024 SLIPW: if SLIP was 7 on the mismatch, go to FAILED instead and leave SLIP at 7.
REQ-025 LOCK: at each strobe, WORD <= window and WORD_VALID=1 for the following cycle; LOCKED=1; no further pattern checking.
REQ-026 FAILED: FAIL=1, DDR_E=0; hold until START or reset.
REQ-027 DDR_E SHALL be 1 in TRAIN, SLIPW and LOCK, and 0 otherwise.
REQ-028 START in any state other than PRST SHALL restart from PRST with SLIP=0 and LOCKED=FAIL=0.
REQ-029 START in PRST SHALL be ignored.
REQ-030 WORD SHALL hold its last value outside strobes.

Reset
REQ-031 When RST_N=0 at a CLK edge, state SHALL become IDLE and all outputs, including DDR_R, DDR_E and WORD, SHALL be 0.
REQ-032 Reset SHALL override START in the same cycle.
REQ-033 Reset mid-TRAIN or mid-LOCK SHALL abandon alignment, and SLIP SHALL return to 0.

Structure
REQ-034 A shared package iddr_pkg SHALL hold the state enumeration, the WORD_W=8 and HIST_W=16 constants, and the SLIP width.
REQ-035 One sub-module iddr_gearbox SHALL contain the history shift, phase counter and window mux; the FSM SHALL stay in iddr_align_ctrl.

Verification
REQ-036 Reset then START, with serial stream 0xA5 repeating aligned at offset 0 -> DDR_R high exactly 4 cycles; LOCKED after 4 matching strobes; SLIP=0; WORD=0xA5 with WORD_VALID every 4 cycles.
REQ-037 Same stream delayed 3 bits -> SLIP steps 1,2,3 with 2 discarded strobes each; lock at SLIP=3; WORD=0xA5.
REQ-038 Constant stream 0x00 with PATTERN=0xA5 -> SLIP reaches 7, then FAIL=1, DDR_E=0, LOCKED=0.
REQ-039 RST_N low for 1 cycle while LOCKED -> next cycle all outputs 0 and state IDLE; a following START relocks.
REQ-040 START asserted during LOCK -> LOCKED drops, DDR_R pulses for RST_CYC cycles, SLIP=0, relock; START during PRST is ignored (pulse length unchanged).
REQ-041 MATCH_N=1 with a single corrupted word after lock -> LOCKED stays 1 and the corrupted WORD is delivered unchanged.

Source files
------------

// File: rtl/iddr_pkg.sv
// rtl/iddr_pkg.sv - shared types and widths for the I_DDR bit-slip alignment controller
package iddr_pkg;

    localparam int WORD_W = 8;
    localparam int HIST_W = 16;
    localparam int SLIP_W = 3;

    localparam logic [SLIP_W-1:0] SLIP_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRST,
        ST_TRAIN,
        ST_SLIPW,
        ST_LOCK,
        ST_FAILED
    } state_e;

endpackage

// File: rtl/iddr_gearbox.sv
// rtl/iddr_gearbox.sv - 2-bit to 8-bit gearbox: history shift register, word phase and slip window mux
module iddr_gearbox
    import iddr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [1:0]        ddr_q,
    input  logic [SLIP_W-1:0] slip,
    output logic [WORD_W-1:0] window,
    output logic              strobe
);

    logic [HIST_W-1:0] hist_q, hist_d;
    logic [1:0]        phase_q, phase_d;
    logic              strobe_q, strobe_d;

    // Strobe is registered so the window it qualifies already holds the phase-3 pair.
    always_comb begin
        hist_d   = hist_q;
        phase_d  = phase_q;
        strobe_d = 1'b0;
        if (clr) begin
            hist_d  = '0;
            phase_d = '0;
        end else if (en) begin
            hist_d   = {hist_q[HIST_W-3:0], ddr_q[0], ddr_q[1]};
            phase_d  = phase_q + 2'd1;
            strobe_d = (phase_q == 2'd3);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q   <= '0;
            phase_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            phase_q  <= phase_d;
            strobe_q <= strobe_d;
        end
    end

    assign window = WORD_W'(hist_q >> slip);
    assign strobe = strobe_q;

endmodule

// File: rtl/iddr_align_ctrl.sv
// rtl/iddr_align_ctrl.sv - I_DDR reset, training-word bit-slip search and locked word delivery
module iddr_align_ctrl
    import iddr_pkg::*;
#(
    parameter int MATCH_N = 4,
    parameter int RST_CYC = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic [7:0] PATTERN,
    input  logic [1:0] DDR_Q,
    output logic       DDR_R,
    output logic       DDR_E,
    output logic [7:0] WORD,
    output logic       WORD_VALID,
    output logic       LOCKED,
    output logic       FAIL,
    output logic [2:0] SLIP
);

    localparam logic [3:0] MATCH_LAST = 4'(MATCH_N - 1);
    localparam logic [3:0] RST_LAST   = 4'(RST_CYC - 1);

    state_e              state_q, state_d;
    logic [3:0]          rst_cnt_q, rst_cnt_d;
    logic [3:0]          match_cnt_q, match_cnt_d;
    logic                disc_q, disc_d;
    logic [SLIP_W-1:0]   slip_q, slip_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                word_valid_q, word_valid_d;
    logic                locked_q, locked_d;
    logic                fail_q, fail_d;
    logic                ddr_r_q, ddr_r_d;
    logic                ddr_e_q, ddr_e_d;

    logic [WORD_W-1:0]   window;
    logic                strobe;
    logic                gb_clr;

    assign gb_clr = (state_q == ST_PRST);

    iddr_gearbox u_gearbox (
        .clk    (CLK),
        .rst_n  (RST_N),
        .en     (ddr_e_q),
        .clr    (gb_clr),
        .ddr_q  (DDR_Q),
        .slip   (slip_q),
        .window (window),
        .strobe (strobe)
    );

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        match_cnt_d  = match_cnt_q;
        disc_d       = disc_q;
        slip_d       = slip_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        locked_d     = locked_q;
        fail_d       = fail_q;
        ddr_r_d      = ddr_r_q;
        ddr_e_d      = ddr_e_q;
        if (START && state_q != ST_PRST) begin
            state_d   = ST_PRST;
            rst_cnt_d = '0;
            slip_d    = '0;
            locked_d  = 1'b0;
            fail_d    = 1'b0;
            ddr_r_d   = 1'b1;
            ddr_e_d   = 1'b0;
        end else begin
            case (state_q)
                ST_PRST: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_d     = ST_TRAIN;
                        match_cnt_d = '0;
                        ddr_r_d     = 1'b0;
                        ddr_e_d     = 1'b1;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 4'd1;
                    end
                end
                ST_TRAIN: begin
                    if (strobe) begin
                        if (window == PATTERN) begin
                            if (match_cnt_q == MATCH_LAST) begin
                                state_d  = ST_LOCK;
                                locked_d = 1'b1;
                            end else begin
                                match_cnt_d = match_cnt_q + 4'd1;
                            end
                        end else begin
                            match_cnt_d = '0;
                            if (slip_q == SLIP_MAX) begin
                                state_d = ST_FAILED;
                                fail_d  = 1'b1;
                                ddr_e_d = 1'b0;
                            end else begin
                                state_d = ST_SLIPW;
                                slip_d  = slip_q + 3'd1;
                                disc_d  = 1'b0;
                            end
                        end
                    end
                end
                // Two strobes are dropped so the window is re-evaluated only on fully settled words.
                ST_SLIPW: begin
                    if (strobe) begin
                        if (disc_q) begin
                            state_d = ST_TRAIN;
                        end else begin
                            disc_d = 1'b1;
                        end
                    end
                end
                ST_LOCK: begin
                    if (strobe) begin
                        word_d       = window;
                        word_valid_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            rst_cnt_q    <= '0;
            match_cnt_q  <= '0;
            disc_q       <= 1'b0;
            slip_q       <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
            ddr_r_q      <= 1'b0;
            ddr_e_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            match_cnt_q  <= match_cnt_d;
            disc_q       <= disc_d;
            slip_q       <= slip_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            locked_q     <= locked_d;
            fail_q       <= fail_d;
            ddr_r_q      <= ddr_r_d;
            ddr_e_q      <= ddr_e_d;
        end
    end

    assign DDR_R      = ddr_r_q;
    assign DDR_E      = ddr_e_q;
    assign WORD       = word_q;
    assign WORD_VALID = word_valid_q;
    assign LOCKED     = locked_q;
    assign FAIL       = fail_q;
    assign SLIP       = slip_q;

endmodule

// File: tb/tb_iddr_align_ctrl.sv
// tb/tb_iddr_align_ctrl.sv - directed and randomized bench for iddr_align_ctrl against a word-level model
module tb_iddr_align_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       START;
    logic [7:0] PATTERN;
    logic [1:0] DDR_Q;

    logic       a_r, a_e, a_wv, a_lk, a_fl;
    logic [7:0] a_w;
    logic [2:0] a_s;
    logic       b_r, b_e, b_wv, b_lk, b_fl;
    logic [7:0] b_w;
    logic [2:0] b_s;

    iddr_align_ctrl #(.MATCH_N(4), .RST_CYC(4)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .START(START), .PATTERN(PATTERN), .DDR_Q(DDR_Q),
        .DDR_R(a_r), .DDR_E(a_e), .WORD(a_w), .WORD_VALID(a_wv),
        .LOCKED(a_lk), .FAIL(a_fl), .SLIP(a_s)
    );

    iddr_align_ctrl #(.MATCH_N(1), .RST_CYC(2)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .START(START), .PATTERN(PATTERN), .DDR_Q(DDR_Q),
        .DDR_R(b_r), .DDR_E(b_e), .WORD(b_w), .WORD_VALID(b_wv),
        .LOCKED(b_lk), .FAIL(b_fl), .SLIP(b_s)
    );

    always #5 CLK = ~CLK;

    int   n_checks = 0;
    int   n_err = 0;
    bit   sel_b = 1'b0;
    int   mn = 4;
    int   rc = 4;
    bit   bits [0:511];

    int         m_mode, m_slip, m_cnt, m_disc;
    bit         m_locked, m_fail, m_wv;
    logic [7:0] m_word;

    logic       o_r, o_e, o_wv, o_lk, o_fl;
    logic [7:0] o_w;
    logic [2:0] o_s;

    always_comb begin
        o_r = a_r; o_e = a_e; o_wv = a_wv; o_lk = a_lk; o_fl = a_fl; o_w = a_w; o_s = a_s;
        if (sel_b) begin
            o_r = b_r; o_e = b_e; o_wv = b_wv; o_lk = b_lk; o_fl = b_fl; o_w = b_w; o_s = b_s;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic r, input logic e, input logic wv,
                               input logic lk, input logic fl, input logic [7:0] w, input logic [2:0] s);
        chk({tag, ".DDR_R"}, 32'(o_r), 32'(r));
        chk({tag, ".DDR_E"}, 32'(o_e), 32'(e));
        chk({tag, ".WORD_VALID"}, 32'(o_wv), 32'(wv));
        chk({tag, ".LOCKED"}, 32'(o_lk), 32'(lk));
        chk({tag, ".FAIL"}, 32'(o_fl), 32'(fl));
        chk({tag, ".WORD"}, 32'(o_w), 32'(w));
        chk({tag, ".SLIP"}, 32'(o_s), 32'(s));
    endtask

    // kind 0: pattern repeated, framed so slip d recovers it; 1: all zeros; 2: random bits
    task automatic build(input int kind, input logic [7:0] pat, input int d, input int cw);
        for (int j = 0; j < 512; j++) begin
            case (kind)
                0: bits[j] = pat[7 - ((j + d) % 8)];
                1: bits[j] = 1'b0;
                default: bits[j] = 1'($urandom_range(0, 1));
            endcase
            if (cw >= 0 && j / 8 == cw) bits[j] = ~bits[j];
        end
    endtask

    // Word at strobe w seen through slip s: stream bits 8w-s .. 8w+7-s, earliest in the MSB.
    function automatic logic [7:0] win(input int w, input int s);
        logic [7:0] v;
        int idx;
        for (int i = 0; i < 8; i++) begin
            idx = 8 * w - s + i;
            v[7 - i] = (idx < 0) ? 1'b0 : bits[idx];
        end
        return v;
    endfunction

    task automatic run(input string tag, input logic [7:0] pat, input int n_words, input int ign_r);
        int ncyc, w, k;
        logic [7:0] cur;
        ncyc = rc + 5 + 4 * n_words;
        PATTERN = pat;
        START = 1'b1;
        step();
        START = 1'b0;
        m_mode = 0; m_slip = 0; m_cnt = 0; m_disc = 0; m_locked = 0; m_fail = 0;
        for (int r = 0; r < ncyc; r++) begin
            m_wv = 0;
            if (!m_fail && r >= rc + 5 && (r - rc - 5) % 4 == 0) begin
                w = (r - rc - 5) / 4;
                cur = win(w, m_slip);
                case (m_mode)
                    0: begin
                        if (cur == pat) begin
                            m_cnt++;
                            if (m_cnt == mn) begin
                                m_mode = 2;
                                m_locked = 1;
                            end
                        end else begin
                            m_cnt = 0;
                            if (m_slip == 7) begin
                                m_mode = 3;
                                m_fail = 1;
                            end else begin
                                m_slip++;
                                m_mode = 1;
                                m_disc = 0;
                            end
                        end
                    end
                    1: begin
                        m_disc++;
                        if (m_disc == 2) m_mode = 0;
                    end
                    2: begin
                        m_word = cur;
                        m_wv = 1;
                    end
                    default: begin
                    end
                endcase
            end
            chk_outputs(tag, 1'(r < rc), 1'(r >= rc && !m_fail), m_wv, m_locked, m_fail,
                        m_word, 3'(m_slip));
            if (r >= rc) begin
                k = r - rc;
                DDR_Q = {bits[2 * k + 1], bits[2 * k]};
            end else begin
                DDR_Q = 2'($urandom);
            end
            START = (r == ign_r);
            step();
        end
        START = 1'b0;
    endtask

    initial begin
        logic [7:0] rp;
        int rd;
        RST_N = 1'b0;
        START = 1'b1;
        PATTERN = 8'h00;
        DDR_Q = 2'b00;
        m_word = 8'h00;
        step();
        step();
        chk_outputs("reset_a", 0, 0, 0, 0, 0, 8'h00, 3'd0);
        sel_b = 1'b1;
        chk_outputs("reset_b", 0, 0, 0, 0, 0, 8'h00, 3'd0);
        sel_b = 1'b0;
        RST_N = 1'b1;
        START = 1'b0;
        step();
        chk_outputs("idle", 0, 0, 0, 0, 0, 8'h00, 3'd0);

        build(0, 8'hA5, 0, -1);
        run("align0", 8'hA5, 8, -1);
        chk("align0.lock_slip", 32'(a_s), 32'd0);
        chk("align0.word", 32'(a_w), 32'hA5);

        RST_N = 1'b0;
        START = 1'b1;
        step();
        m_word = 8'h00;
        chk_outputs("rst_in_lock", 0, 0, 0, 0, 0, 8'h00, 3'd0);
        RST_N = 1'b1;
        START = 1'b0;
        step();
        chk_outputs("rst_idle", 0, 0, 0, 0, 0, 8'h00, 3'd0);
        run("relock", 8'hA5, 8, -1);

        run("restart_in_lock", 8'hA5, 8, 1);

        build(0, 8'hA5, 3, -1);
        run("slip3", 8'hA5, 16, -1);
        chk("slip3.lock_slip", 32'(a_s), 32'd3);
        chk("slip3.word", 32'(a_w), 32'hA5);

        build(1, 8'hA5, 0, -1);
        run("fail", 8'hA5, 26, -1);
        chk("fail.FAIL", 32'(a_fl), 32'd1);
        chk("fail.DDR_E", 32'(a_e), 32'd0);
        chk("fail.SLIP", 32'(a_s), 32'd7);

        for (int it = 0; it < 4; it++) begin
            rp = 8'($urandom);
            rd = int'($urandom_range(0, 7));
            build((it == 3) ? 2 : 0, rp, rd, -1);
            run("random", rp, 30, -1);
        end

        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        step();
        m_word = 8'h00;
        sel_b = 1'b1;
        mn = 1;
        rc = 2;
        build(0, 8'hA5, 0, 3);
        run("match1_corrupt", 8'hA5, 8, -1);
        chk("match1_corrupt.locked_end", 32'(b_lk), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
